// File: rtl/mat_ctrl_pkg.sv
// Shared types for the matrix-multiply controller: packed word, FSM encodings, debug view.
package mat_ctrl_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [3:0][7:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    RUN,
    STORE,
    FIN
  } state_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_WAIT
  } mem_state_e;

  typedef struct packed {
    state_e     ctrl;
    mem_state_e mem;
  } dbg_t;

endpackage

// File: rtl/mat_mem_master.sv
// Single-outstanding memory sequencer: walks idx 0..nwords-1 from base, one transaction at a time.
module mat_mem_master
  import mat_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  nwords,
  input  logic              gnt,
  input  logic              rvalid,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-2:0]  idx,
  output logic              beat,
  output logic              done,
  output mem_state_e        state
);

  mem_state_e            state_q, state_d;
  logic [CNT_W-2:0]      idx_q, idx_d;
  logic                  last;

  // Handshake: req stays high with addr held until the cycle gnt is sampled; the
  // transaction then completes on rvalid, and no new req is raised before that.
  assign last  = ({1'b0, idx_q} == (nwords - CNT_W'(1)));
  assign req   = (state_q == M_REQ);
  assign addr  = req ? (base + ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES)) : '0;
  assign beat  = (state_q == M_WAIT) && rvalid;
  assign done  = beat && last;
  assign idx   = idx_q;
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= M_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      M_REQ:  if (gnt) state_d = M_WAIT;
      M_WAIT: if (rvalid) begin
        if (last) begin
          state_d = M_IDLE;
        end else begin
          state_d = M_REQ;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = M_IDLE;
    endcase
    // A new phase may be launched in the same cycle the previous one finishes.
    if (go) begin
      state_d = M_REQ;
      idx_d   = '0;
    end
  end

endmodule

// File: rtl/mat_mult_ctrl.sv
// Matrix-multiply job controller: fetch A/B, run the engine, store C, raise irq.
// Optional engine watchdog is built in when MMCTRL_TIMEOUT_EN is defined.
module mat_mult_ctrl
  import mat_ctrl_pkg::*;
#(
  parameter int NWORDS = 256,
  parameter int ADDR_W = 32
`ifdef MMCTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start_i,
  input  logic [ADDR_W-1:0]              cfg_a_addr_i,
  input  logic [ADDR_W-1:0]              cfg_b_addr_i,
  input  logic [ADDR_W-1:0]              cfg_c_addr_i,
  input  logic [$clog2(NWORDS):0]        cfg_nwords_i,
  output logic                           busy_o,
  output logic                           irq_o,
  output logic                           err_o,
  output logic                           data_req_o,
  input  logic                           data_gnt_i,
  input  logic                           data_rvalid_i,
  output logic [ADDR_W-1:0]              data_addr_o,
  output logic                           data_we_o,
  output logic [3:0]                     data_be_o,
  output logic [31:0]                    data_wdata_o,
  input  logic [31:0]                    data_rdata_i,
  output logic                           mm_start_o,
  input  logic                           mm_done_i,
  output word_t                          mm_mat_a_o [NWORDS],
  output word_t                          mm_mat_b_o [NWORDS],
  input  word_t                          mm_mat_c_i [NWORDS],
  output dbg_t                           dbg_o
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam int CNT_W = IDX_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q, c_addr_q, base;
  logic [CNT_W-1:0]  nwords_q;
  logic              irq_q, go, capture, req, beat, done;
  logic [IDX_W-1:0]  idx;
  mem_state_e        mstate;
  word_t             c_buf [NWORDS];

`ifdef MMCTRL_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        err_q, tmo_hit;

  assign tmo_hit = (state_q == RUN) && !mm_done_i && (tmo_q == 32'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= ((state_q == RUN) && (state_d == RUN)) ? tmo_q + 32'd1 : '0;
      if ((state_q == IDLE) && cfg_start_i) err_q <= 1'b0;
      else if (tmo_hit)                     err_q <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (cfg_start_i) begin
        if (cfg_nwords_i == '0) begin
          state_d = FIN;
        end else begin
          state_d = LOAD_A;
          go      = 1'b1;
        end
      end
      LOAD_A: if (done) begin
        state_d = LOAD_B;
        go      = 1'b1;
      end
      LOAD_B: if (done) state_d = RUN;
      RUN: begin
        if (mm_done_i) begin
          state_d = STORE;
          go      = 1'b1;
          capture = 1'b1;
        end
`ifdef MMCTRL_TIMEOUT_EN
        else if (tmo_hit) state_d = FIN;
`endif
      end
      STORE:   if (done) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base = a_addr_q;
    if (state_q == LOAD_B)     base = b_addr_q;
    else if (state_q == STORE) base = c_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      nwords_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // irq fires as the FSM re-enters IDLE, so it coincides with busy falling.
      irq_q   <= (state_q == FIN);
      if ((state_q == IDLE) && cfg_start_i) begin
        a_addr_q <= cfg_a_addr_i;
        b_addr_q <= cfg_b_addr_i;
        c_addr_q <= cfg_c_addr_i;
        nwords_q <= cfg_nwords_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) begin
        mm_mat_a_o[i] <= '0;
        mm_mat_b_o[i] <= '0;
        c_buf[i]      <= '0;
      end
    end else begin
      if (beat && (state_q == LOAD_A)) mm_mat_a_o[idx] <= data_rdata_i;
      if (beat && (state_q == LOAD_B)) mm_mat_b_o[idx] <= data_rdata_i;
      if (capture) begin
        for (int i = 0; i < NWORDS; i++) begin
          if (CNT_W'(i) < nwords_q) c_buf[i] <= mm_mat_c_i[i];
        end
      end
    end
  end

  mat_mem_master #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .base   (base),
    .nwords (nwords_q),
    .gnt    (data_gnt_i),
    .rvalid (data_rvalid_i),
    .req    (req),
    .addr   (data_addr_o),
    .idx    (idx),
    .beat   (beat),
    .done   (done),
    .state  (mstate)
  );

  assign busy_o       = (state_q != IDLE);
  assign irq_o        = irq_q;
  assign mm_start_o   = (state_q == RUN);
  assign data_req_o   = req;
  assign data_we_o    = req && (state_q == STORE);
  assign data_be_o    = 4'hF;
  assign data_wdata_o = data_we_o ? c_buf[idx] : '0;
  assign dbg_o        = {state_q, mstate};

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Self-checking bench for mat_mult_ctrl: memory/engine models, transaction scoreboard, directed jobs.
// Define MMCTRL_TIMEOUT_EN to also exercise the engine watchdog.
module tb_mat_mult_ctrl;
  import mat_ctrl_pkg::*;

  localparam int NW = 8;
  localparam int CW = $clog2(NW) + 1;
`ifdef MMCTRL_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [31:0]   cfg_a = '0, cfg_b = '0, cfg_c = '0;
  logic [CW-1:0] cfg_nwords = '0;
  logic          busy, irq, err, data_req, data_gnt, data_rvalid, data_we, mm_start, mm_done;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic [3:0]    data_be;
  word_t         mm_mat_a [NW];
  word_t         mm_mat_b [NW];
  word_t         mm_mat_c [NW];
  dbg_t          dbg;

  mat_mult_ctrl #(
    .NWORDS (NW),
    .ADDR_W (32)
`ifdef MMCTRL_TIMEOUT_EN
    , .TIMEOUT_CYC (TMO)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start_i   (cfg_start),
    .cfg_a_addr_i  (cfg_a),
    .cfg_b_addr_i  (cfg_b),
    .cfg_c_addr_i  (cfg_c),
    .cfg_nwords_i  (cfg_nwords),
    .busy_o        (busy),
    .irq_o         (irq),
    .err_o         (err),
    .data_req_o    (data_req),
    .data_gnt_i    (data_gnt),
    .data_rvalid_i (data_rvalid),
    .data_addr_o   (data_addr),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_wdata_o  (data_wdata),
    .data_rdata_i  (data_rdata),
    .mm_start_o    (mm_start),
    .mm_done_i     (mm_done),
    .mm_mat_a_o    (mm_mat_a),
    .mm_mat_b_o    (mm_mat_b),
    .mm_mat_c_i    (mm_mat_c),
    .dbg_o         (dbg)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
  int stall_max = 0, rv_max = 1, eng_delay = 10;
  bit eng_en = 1'b1;
  int n_rd = 0, n_wr = 0, irq_cnt = 0, start_hi = 0, req_cnt = 0;
  int irq0, rd0, wr0, st0, cur_n;
  bit cur_store;
  logic [31:0] cur_c;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_a [NW];
  logic [31:0] exp_b [NW];
  logic [64:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory slave: random grant stall, random response latency, protocol checks.
  initial begin : responder
    bit pend, seen;
    int stall, rvc;
    logic [64:0] held, got, e;
    logic [31:0] rd;
    pend = 0; seen = 0; stall = 0; rvc = 0; rd = '0; held = '0;
    data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      data_gnt = 0; data_rvalid = 0; data_rdata = '0;
      if (!rst_n) begin
        pend = 0; seen = 0;
        continue;
      end
      if (pend) begin
        check("single_outstanding", 64'(data_req), 64'(0));
        if (rvc == 0) begin
          data_rvalid = 1; data_rdata = rd; pend = 0;
        end else rvc--;
      end else if (data_req) begin
        got = {data_we, data_addr, data_wdata};
        if (!seen) begin
          seen = 1; held = got; req_cnt++;
          stall = $urandom_range(stall_max, 0);
        end else begin
          check("req_stable_addr_wdata", got[63:0], held[63:0]);
          check("req_stable_we", 64'(got[64]), 64'(held[64]));
        end
        if (stall == 0) begin
          data_gnt = 1; seen = 0; pend = 1;
          rvc = $urandom_range(rv_max, 1) - 1;
          check("txn_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("txn_we", 64'(got[64]), 64'(e[64]));
            check("txn_addr", 64'(got[63:32]), 64'(e[63:32]));
            if (e[64]) check("txn_wdata", 64'(got[31:0]), 64'(e[31:0]));
          end
          if (got[64]) begin
            mem[got[63:32]] = got[31:0]; n_wr++; rd = '0;
          end else begin
            rd = mem.exists(got[63:32]) ? mem[got[63:32]] : 32'h0; n_rd++;
          end
        end else stall--;
      end
    end
  end

  // Engine model: pulses done eng_delay cycles after start is seen high.
  initial begin : engine
    int cnt;
    cnt = 0; mm_done = 0;
    forever begin
      @(posedge clk);
      #1;
      mm_done = 0;
      if (rst_n && mm_start && eng_en) begin
        if (cnt >= eng_delay) begin
          mm_done = 1; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (irq) irq_cnt++;
        if (mm_start) start_hi++;
      end
    end
  end

  task automatic prep_job(input logic [31:0] a, b, c, input int n, input bit store);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = $urandom; mem[a + 32'(4 * i)] = v; exp_a[i] = v;
      exp_q.push_back({1'b0, a + 32'(4 * i), 32'h0});
    end
    for (int i = 0; i < n; i++) begin
      v = $urandom; mem[b + 32'(4 * i)] = v; exp_b[i] = v;
      exp_q.push_back({1'b0, b + 32'(4 * i), 32'h0});
    end
    for (int i = 0; i < NW; i++) mm_mat_c[i] = $urandom;
    if (store)
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, c + 32'(4 * i), mm_mat_c[i]});
    cur_c = c; cur_n = n; cur_store = store;
    irq0 = irq_cnt; rd0 = n_rd; wr0 = n_wr; st0 = start_hi;
  endtask

  task automatic start_job(input logic [31:0] a, b, c, input int n);
    cfg_a = a; cfg_b = b; cfg_c = c; cfg_nwords = CW'(n);
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic wait_ctrl(input state_e s, input string tag);
    int k;
    k = 0;
    while (dbg.ctrl != s && k < 3000) begin
      tick(); k++;
    end
    check({tag, ":reach_state"}, 64'(dbg.ctrl == s), 64'(1));
  endtask

  task automatic finish_job(input string tag);
    int k, bad;
    k = 0;
    while (irq_cnt == irq0 && k < 4000) begin
      tick(); k++;
    end
    check({tag, ":irq_seen"}, 64'(irq_cnt != irq0), 64'(1));
    repeat (3) tick();
    check({tag, ":irq_once"}, 64'(irq_cnt - irq0), 64'(1));
    check({tag, ":txns_left"}, 64'(exp_q.size()), 64'(0));
    check({tag, ":reads"}, 64'(n_rd - rd0), 64'(2 * cur_n));
    check({tag, ":writes"}, 64'(n_wr - wr0), 64'(cur_store ? cur_n : 0));
    check({tag, ":busy_idle"}, 64'(busy), 64'(0));
    bad = 0;
    for (int i = 0; i < NW; i++) if (mm_mat_a[i] !== exp_a[i]) bad++;
    check({tag, ":a_buf_bad_words"}, 64'(bad), 64'(0));
    bad = 0;
    for (int i = 0; i < NW; i++) if (mm_mat_b[i] !== exp_b[i]) bad++;
    check({tag, ":b_buf_bad_words"}, 64'(bad), 64'(0));
    if (cur_store) begin
      bad = 0;
      for (int i = 0; i < cur_n; i++) if (mem[cur_c + 32'(4 * i)] !== mm_mat_c[i]) bad++;
      check({tag, ":c_mem_bad_words"}, 64'(bad), 64'(0));
    end
  endtask

  task automatic zero_job(input string tag);
    int cyc, r0, s0, i0;
    r0 = req_cnt; s0 = start_hi; i0 = irq_cnt;
    cfg_nwords = '0; cfg_start = 1;
    tick();
    cfg_start = 0; cyc = 1;
    while (!irq && cyc < 20) begin
      tick(); cyc++;
    end
    check({tag, ":irq_latency"}, 64'(cyc), 64'(2));
    check({tag, ":busy_at_irq"}, 64'(busy), 64'(0));
    check({tag, ":err_cleared"}, 64'(err), 64'(0));
    repeat (2) tick();
    check({tag, ":no_req"}, 64'(req_cnt - r0), 64'(0));
    check({tag, ":no_mm_start"}, 64'(start_hi - s0), 64'(0));
    check({tag, ":irq_once"}, 64'(irq_cnt - i0), 64'(1));
  endtask

  initial begin : main
    for (int i = 0; i < NW; i++) begin exp_a[i] = '0; exp_b[i] = '0; mm_mat_c[i] = '0; end
    #2;
    check("rst:busy", 64'(busy), 64'(0));
    check("rst:irq", 64'(irq), 64'(0));
    check("rst:err", 64'(err), 64'(0));
    check("rst:req", 64'(data_req), 64'(0));
    check("rst:mm_start", 64'(mm_start), 64'(0));
    check("rst:a_buf0", 64'(mm_mat_a[0]), 64'(0));
    repeat (2) tick();
    rst_n = 1;
    tick();

    // Basic job, zero-wait memory.
    stall_max = 0; rv_max = 1; eng_delay = 10;
    prep_job(32'h100, 32'h200, 32'h300, 4, 1);
    start_job(32'h100, 32'h200, 32'h300, 4);
    finish_job("t1");
    check("t1:err", 64'(err), 64'(0));

    // Random stalls and latencies, including a full-size job and a short one after it.
    stall_max = 5; rv_max = 4;
    for (int j = 0; j < 3; j++) begin
      eng_delay = $urandom_range(6, 0);
      prep_job(32'h100, 32'h200, 32'h300, 4, 1);
      start_job(32'h100, 32'h200, 32'h300, 4);
      finish_job("t2_n4");
    end
    prep_job(32'h1000, 32'h2000, 32'h3000, NW, 1);
    start_job(32'h1000, 32'h2000, 32'h3000, NW);
    finish_job("t2_full");
    prep_job(32'h4000, 32'h5000, 32'h6000, 2, 1);
    start_job(32'h4000, 32'h5000, 32'h6000, 2);
    finish_job("t2_partial");

    zero_job("t3");

    // Second start pulse during LOAD_B must be ignored.
    prep_job(32'h700, 32'h800, 32'hA00, 3, 1);
    start_job(32'h700, 32'h800, 32'hA00, 3);
    wait_ctrl(LOAD_B, "t4");
    start_job(32'h900, 32'h990, 32'hB00, 1);
    finish_job("t4");

    // Reset during STORE.
    prep_job(32'h1100, 32'h1200, 32'h1300, NW, 1);
    start_job(32'h1100, 32'h1200, 32'h1300, NW);
    wait_ctrl(STORE, "t5");
    tick();
    rst_n = 0;
    #1;
    check("t5:req", 64'(data_req), 64'(0));
    check("t5:we", 64'(data_we), 64'(0));
    check("t5:addr", 64'(data_addr), 64'(0));
    check("t5:busy", 64'(busy), 64'(0));
    check("t5:irq", 64'(irq), 64'(0));
    check("t5:mm_start", 64'(mm_start), 64'(0));
    check("t5:a_buf0", 64'(mm_mat_a[0]), 64'(0));
    repeat (2) tick();
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin exp_a[i] = '0; exp_b[i] = '0; end
    irq0 = irq_cnt;
    rst_n = 1;
    repeat (20) tick();
    check("t5:no_irq_after_reset", 64'(irq_cnt - irq0), 64'(0));
    prep_job(32'h1400, 32'h1500, 32'h1600, 3, 1);
    start_job(32'h1400, 32'h1500, 32'h1600, 3);
    finish_job("t5_clean");

`ifdef MMCTRL_TIMEOUT_EN
    // Engine never finishes: watchdog aborts RUN, skips STORE, flags err.
    eng_en = 0;
    prep_job(32'h1700, 32'h1800, 32'h1900, 2, 0);
    start_job(32'h1700, 32'h1800, 32'h1900, 2);
    finish_job("t6");
    check("t6:run_cycles", 64'(start_hi - st0), 64'(TMO));
    check("t6:err_set", 64'(err), 64'(1));
    eng_en = 1;
    zero_job("t6_clear");
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
